// File: rtl/mtr_drv_dt.sv
// mtr_drv_dt: multi-channel H-bridge PWM driver with dead-time insertion.
// A shared free-running counter sets the PWM period. Each channel samples its
// signed speed command at the period wrap, turns it into a duty value, and runs
// a small FSM. The FSM makes sure the two sides of a pair never conduct
// together and always leaves DEADTIME clocks with both sides off.
// Optional feature macro: SLEW_LIMIT_EN. When it is defined, the applied speed
// moves toward the command by at most SLEW_STEP per period.
module mtr_drv_dt #(
  parameter int NUM_CH    = 2,
  parameter int PWM_W     = 11,
  parameter int SPD_W     = 11,
  parameter int DEADTIME  = 6,
  parameter int SLEW_STEP = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic [NUM_CH-1:0]       brake,
  output logic [NUM_CH-1:0]       pwm_p,
  output logic [NUM_CH-1:0]       pwm_n,
  output logic                    period_sync
);

  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [7:0]       DEAD_LD  = 8'(DEADTIME);

  if (SPD_W > PWM_W || DEADTIME < 1 || DEADTIME > 255 || SLEW_STEP < 1) begin : g_bad_param
    $error("mtr_drv_dt: illegal parameter combination");
  end

  typedef enum logic [1:0] {P_ON, N_ON, DEAD, BRK} ch_state_e;

  // Offset-binary conversion: sign-extend, then add half scale (wraps mod 2^PWM_W)
  function automatic logic [PWM_W-1:0] speed_to_duty(input logic signed [SPD_W-1:0] s);
    logic [PWM_W-1:0] ext;
    ext = PWM_W'(s);
    return ext + DUTY_MID;
  endfunction

`ifdef SLEW_LIMIT_EN
  // Step toward the target by at most SLEW_STEP, landing exactly on it when close
  function automatic logic signed [SPD_W-1:0] slew_limit(
    input logic signed [SPD_W-1:0] cur,
    input logic signed [SPD_W-1:0] tgt
  );
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (t > c + SLEW_STEP) return SPD_W'(c + SLEW_STEP);
    if (t < c - SLEW_STEP) return SPD_W'(c - SLEW_STEP);
    return tgt;
  endfunction
`endif

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             sync_q;
  logic             wrap;

  assign cnt_d       = cnt_q + 1'b1;
  assign wrap        = (cnt_q == CNT_MAX);
  assign period_sync = sync_q;

  // Shared period counter; sync is registered so it lines up with cnt == max
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= (cnt_d == CNT_MAX);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [SPD_W-1:0] spd_k;
    logic signed [SPD_W-1:0] app_q, app_d;
    logic [PWM_W-1:0]        duty;
    logic                    raw;
    ch_state_e               state_q, state_d;
    logic [7:0]              dead_q, dead_d;
    logic                    p_q, n_q;

    assign spd_k    = spd[k*SPD_W +: SPD_W];
    assign duty     = speed_to_duty(app_q);
    assign raw      = (cnt_q < duty);
    assign pwm_p[k] = p_q;
    assign pwm_n[k] = n_q;

    // Applied speed: brake forces zero (and wins over the wrap), else load at wrap
    always_comb begin
      app_d = app_q;
      if (brake[k]) begin
        app_d = '0;
      end else if (wrap) begin
`ifdef SLEW_LIMIT_EN
        app_d = slew_limit(app_q, spd_k);
`else
        app_d = spd_k;
`endif
      end
    end

    // Side selection with dead-time; a raw toggle inside DEAD does not restart it
    always_comb begin
      state_d = state_q;
      dead_d  = dead_q;
      if (brake[k]) begin
        state_d = BRK;
      end else begin
        case (state_q)
          P_ON: if (!raw) begin
            state_d = DEAD;
            dead_d  = DEAD_LD;
          end
          N_ON: if (raw) begin
            state_d = DEAD;
            dead_d  = DEAD_LD;
          end
          DEAD: begin
            dead_d = dead_q - 8'd1;
            if (dead_q <= 8'd1) state_d = raw ? P_ON : N_ON;
          end
          BRK: begin
            state_d = DEAD;
            dead_d  = DEAD_LD;
          end
          default: begin
            state_d = DEAD;
            dead_d  = DEAD_LD;
          end
        endcase
      end
    end

    // Channel state and registered pin drive (decoded from the next state)
    always_ff @(posedge clk) begin
      if (rst) begin
        app_q   <= '0;
        state_q <= DEAD;
        dead_q  <= DEAD_LD;
        p_q     <= 1'b0;
        n_q     <= 1'b0;
      end else begin
        app_q   <= app_d;
        state_q <= state_d;
        dead_q  <= dead_d;
        p_q     <= (state_d == P_ON);
        n_q     <= (state_d == N_ON);
      end
    end
  end

endmodule

// File: tb/tb_mtr_drv_dt.sv
// tb_mtr_drv_dt: directed waveform measurements plus randomized speed/brake/reset
// traffic, checked every cycle against a behavioural model of the driver.
module tb_mtr_drv_dt;
  localparam int NUM_CH    = 2;
  localparam int PWM_W     = 11;
  localparam int SPD_W     = 11;
  localparam int DEADTIME  = 6;
  localparam int SLEW_STEP = 64;
  localparam int PERIOD    = 1 << PWM_W;
  localparam int MID       = 1 << (PWM_W - 1);
  localparam int SPD_MIN   = -(1 << (SPD_W - 1));
  localparam int SPD_MAX   = (1 << (SPD_W - 1)) - 1;
`ifdef SLEW_LIMIT_EN
  localparam int LIM = SLEW_STEP;
`else
  localparam int LIM = 1 << (SPD_W + 1);
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH*SPD_W-1:0] spd;
  logic [NUM_CH-1:0] brake;
  logic [NUM_CH-1:0] pwm_p;
  logic [NUM_CH-1:0] pwm_n;
  logic period_sync;

  int n_cmp = 0;
  int n_bad = 0;

  mtr_drv_dt #(
    .NUM_CH(NUM_CH), .PWM_W(PWM_W), .SPD_W(SPD_W),
    .DEADTIME(DEADTIME), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .clk(clk), .rst(rst), .spd(spd), .brake(brake),
    .pwm_p(pwm_p), .pwm_n(pwm_n), .period_sync(period_sync)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int spd_cmd [NUM_CH];
  int m_cnt;
  int m_app   [NUM_CH];
  int m_on    [NUM_CH];   // +1 high side driven, -1 low side driven, 0 both off
  int m_blank [NUM_CH];   // off-clocks still owed before a side may drive
  bit m_brk   [NUM_CH];
  bit m_ok = 1'b0;

  function automatic int model_next(input int cur, input int tgt);
    if (tgt > cur + LIM) return cur + LIM;
    if (tgt < cur - LIM) return cur - LIM;
    return tgt;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_app[c] = 0; m_on[c] = 0; m_blank[c] = DEADTIME; m_brk[c] = 1'b0;
      end
      m_ok = 1'b1;
    end else if (m_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        int want;
        want = (m_cnt < m_app[c] + MID) ? 1 : -1;
        if (brake[c]) begin
          m_brk[c] = 1'b1; m_on[c] = 0;
        end else if (m_brk[c]) begin
          m_brk[c] = 1'b0; m_blank[c] = DEADTIME;
        end else if (m_on[c] == 0) begin
          m_blank[c]--;
          if (m_blank[c] == 0) m_on[c] = want;
        end else if (m_on[c] != want) begin
          m_on[c] = 0; m_blank[c] = DEADTIME;
        end
        if (brake[c]) m_app[c] = 0;
        else if (m_cnt == PERIOD - 1) m_app[c] = model_next(m_app[c], spd_cmd[c]);
      end
      m_cnt = (m_cnt + 1) % PERIOD;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_ok) begin
      for (int c = 0; c < NUM_CH; c++) begin
        n_cmp++;
        if (pwm_p[c] !== (m_on[c] == 1) || pwm_n[c] !== (m_on[c] == -1)) begin
          n_bad++;
          $display("FAIL pins ch%0d t=%0t cnt=%0d: p,n=%b,%b required %b,%b", c, $time, m_cnt,
                   pwm_p[c], pwm_n[c], (m_on[c] == 1), (m_on[c] == -1));
        end
      end
      n_cmp++;
      if (period_sync !== (m_cnt == PERIOD - 1)) begin
        n_bad++;
        $display("FAIL sync t=%0t cnt=%0d: got %b required %b", $time, m_cnt, period_sync,
                 (m_cnt == PERIOD - 1));
      end
      n_cmp++;
      if ((pwm_p & pwm_n) !== '0) begin
        n_bad++;
        $display("FAIL overlap t=%0t: p&n=%b required 0", $time, pwm_p & pwm_n);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_spd(input int c, input int v);
    logic [SPD_W-1:0] f;
    spd_cmd[c] = v;
    f = SPD_W'(v);
    spd[c*SPD_W +: SPD_W] = f;
  endtask

  // Observe one full period of channel ch starting at cnt 0.
  // ev_kind 1: set spd of ch to ev_val at cnt ev_at; 2: brake ch from ev_at for ev_len clocks.
  task automatic measure(input int ch, input int ev_kind, input int ev_at, input int ev_len,
                         input int ev_val, output int p_hi, output int n_hi, output int p_fall,
                         output int sync_n, output int sync_at, output int lo_run,
                         output int p_probe);
    int guard;
    bit prev_p, run_open;
    guard = 0;
    while (m_cnt != 0 && guard < PERIOD + 4) begin
      @(negedge clk);
      guard++;
    end
    chk("period_align", m_cnt, 0);
    p_hi = 0; n_hi = 0; p_fall = -1; sync_n = 0; sync_at = -1; lo_run = 0; p_probe = -1;
    prev_p = 1'b0; run_open = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      if (pwm_p[ch]) p_hi++;
      if (pwm_n[ch]) n_hi++;
      if (prev_p && !pwm_p[ch] && p_fall < 0) p_fall = i;
      prev_p = pwm_p[ch];
      if (period_sync) begin sync_n++; sync_at = i; end
      if (ev_kind == 2) begin
        if (i == ev_at + 1) run_open = 1'b1;
        if (run_open) begin
          if (!pwm_p[ch] && !pwm_n[ch]) lo_run++;
          else run_open = 1'b0;
        end
        if (i == ev_at + ev_len + DEADTIME + 1) p_probe = int'(pwm_p[ch]);
      end
      if (ev_kind == 1 && i == ev_at) set_spd(ch, ev_val);
      if (ev_kind == 2 && i == ev_at) brake[ch] = 1'b1;
      if (ev_kind == 2 && i == ev_at + ev_len) brake[ch] = 1'b0;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ph, nh, pf, sn, sa, lr, pp;
    rst = 1'b1;
    brake = '0;
    spd = '0;
    for (int c = 0; c < NUM_CH; c++) spd_cmd[c] = 0;
    repeat (3) @(negedge clk);
    chk("reset_pwm_p", int'(pwm_p), 0);
    chk("reset_pwm_n", int'(pwm_n), 0);
    chk("reset_sync", int'(period_sync), 0);
    rst = 1'b0;

`ifndef SLEW_LIMIT_EN
    // zero speed: symmetric waveform with dead bands
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("zero_p_high", ph, 1018);
    chk("zero_n_high", nh, 1018);
    chk("zero_both_low", PERIOD - ph - nh, 12);
    chk("sync_per_period", sn, 1);
    chk("sync_position", sa, 2047);

    // full positive: one-clock raw low becomes a 6-clock gap, n never drives
    set_spd(0, SPD_MAX);
    repeat (2) measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("fullpos_p_low", PERIOD - ph, 6);
    chk("fullpos_n_high", nh, 0);

    // full negative: duty 0, low side constantly on
    set_spd(0, SPD_MIN);
    repeat (2) measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("fullneg_p_high", ph, 0);
    chk("fullneg_n_high", nh, 2048);

    // mid-period command change waits for the wrap
    measure(1, 1, 500, 0, 256, ph, nh, pf, sn, sa, lr, pp);
    chk("midchange_cur_fall", pf, 1025);
    measure(1, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("midchange_next_fall", pf, 1281);

    // brake ch1 for 100 clocks from cnt 300; resume at half duty
    measure(1, 2, 300, 100, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("brake_low_run", lr, 106);
    chk("brake_resume_p", pp, 1);
    chk("brake_p_high", ph, 912);
`else
    // slew: 0 -> +512 climbs 64 per period and then holds
    begin
      int hist [10];
      set_spd(0, 512);
      for (int k = 0; k < 10; k++) begin
        measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
        hist[k] = ph;
      end
      chk("slew_p1", hist[1], 1082);
      chk("slew_p2", hist[2], 1146);
      chk("slew_p8", hist[8], 1530);
      chk("slew_p9", hist[9], 1530);
    end
    repeat (700) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("slew_rst_p", int'(pwm_p), 0);
    chk("slew_rst_n", int'(pwm_n), 0);
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    measure(0, 0, 0, 0, 0, ph, nh, pf, sn, sa, lr, pp);
    chk("slew_restart_p1", ph, 1082);
`endif

    // brake asserted exactly in a wrap cycle together with a new command
    while (m_cnt != PERIOD - 1) @(negedge clk);
    set_spd(0, 300);
    brake[0] = 1'b1;
    repeat (3) @(negedge clk);
    brake[0] = 1'b0;

    // randomized traffic with a mid-run reset pulse
    for (int t = 0; t < 12000; t++) begin
      int c;
      c = int'($urandom_range(NUM_CH - 1, 0));
      if ($urandom_range(149, 0) == 0)
        set_spd(c, int'($urandom_range(SPD_MAX - SPD_MIN, 0)) + SPD_MIN);
      if ($urandom_range(299, 0) == 0) brake[c] = ~brake[c];
      if ($urandom_range(999, 0) == 0) brake[c] = 1'b1;
      if (t == 6000) rst = 1'b1;
      if (t == 6002) rst = 1'b0;
      @(negedge clk);
    end
    brake = '0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
